clk_ref_monitor_div: RTL and testbench

CLK_REF_MONITOR_DIV -- requirements
Module: clk_ref_monitor_div

---
 rtl/clk_ref_monitor_div.sv | 157 +++++++++++++++
 tb/tb_clk_ref_monitor_div.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_ref_monitor_div.sv
// Reference clock monitor with per-channel clock-enable dividers.
// Counts synchronised ref_in rising edges per fixed window, locks after
// LOCK_WIN consecutive in-range windows, and drives N_CH divided enables
// ticked by the reference when locked or by the local clock in holdover.

// One divider channel: counts ticks, pulses ce one cycle after the tick
// that reaches the (possibly just changed) ratio.
module clk_ref_monitor_div_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             clr,
  input  logic [DIV_W-1:0] ratio,
  output logic             ce
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] ratio_m1;

  // Ratio 0 behaves like 1; >= compare lets a lowered ratio fire at once.
  assign ratio_m1 = (ratio == '0) ? '0 : ratio - DIV_W'(1);

  // Divider counter and registered enable pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ce  <= 1'b0;
    end else if (tick) begin
      if (cnt >= ratio_m1) begin
        cnt <= '0;
        ce  <= 1'b1;
      end else begin
        cnt <= cnt + DIV_W'(1);
        ce  <= 1'b0;
      end
    end else begin
      ce <= 1'b0;
    end
  end
endmodule

module clk_ref_monitor_div #(
  parameter int N_CH     = 2,
  parameter int DIV_W    = 8,
  parameter int WIN_CYC  = 1024,
  parameter int REF_MIN  = 240,
  parameter int REF_MAX  = 272,
  parameter int LOCK_WIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ref_in,
  input  logic [N_CH*DIV_W-1:0] div_ratio,
  output logic                  ref_ok,
  output logic [N_CH-1:0]       ce_out,
  output logic [15:0]           edge_count
);
  localparam int WIN_W = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
  localparam int GC_W  = $clog2(LOCK_WIN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
  localparam logic [15:0]      REF_LO   = 16'(REF_MIN);
  localparam logic [15:0]      REF_HI   = 16'(REF_MAX);
  localparam logic [GC_W-1:0]  GC_FULL  = GC_W'(LOCK_WIN);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic             sync1, sync2, ref_hist;
  logic             ref_edge;
  logic [WIN_W-1:0] win_cnt;
  logic             win_last;
  logic [15:0]      edge_acc;
  logic [15:0]      edge_tot;
  logic             win_good;
  logic [GC_W-1:0]  good_cnt;
  logic [GC_W-1:0]  good_inc;
  logic             go_lock, go_search, trans;
  logic             tick;

  // Two-flop synchroniser plus history flop for rising-edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      ref_hist <= 1'b0;
    end else begin
      sync1    <= ref_in;
      sync2    <= sync1;
      ref_hist <= sync2;
    end
  end

  assign ref_edge = sync2 & ~ref_hist;
  assign win_last = (win_cnt == WIN_LAST);

  // Count including an edge landing in the current cycle, saturating.
  assign edge_tot = (ref_edge && edge_acc != 16'hFFFF) ? edge_acc + 16'd1 : edge_acc;
  assign win_good = (edge_tot >= REF_LO) && (edge_tot <= REF_HI);
  assign good_inc = (good_cnt == GC_FULL) ? good_cnt : good_cnt + GC_W'(1);

  assign go_lock   = win_last && win_good && (state == SEARCH) && (good_inc == GC_FULL);
  assign go_search = win_last && !win_good && (state == LOCKED);
  assign trans     = go_lock | go_search;

  // Locked: divide the reference; searching: hold over on the local clock.
  assign tick = (state == LOCKED) ? ref_edge : 1'b1;

  // Window counter and per-window edge accumulator; publish total at window end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt    <= '0;
      edge_acc   <= '0;
      edge_count <= '0;
    end else if (win_last) begin
      win_cnt    <= '0;
      edge_acc   <= '0;
      edge_count <= edge_tot;
    end else begin
      win_cnt  <= win_cnt + WIN_W'(1);
      edge_acc <= edge_tot;
    end
  end

  // Lock FSM with good-window streak and registered ref_ok.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      ref_ok   <= 1'b0;
    end else if (win_last) begin
      good_cnt <= win_good ? good_inc : '0;
      if (go_lock) begin
        state  <= LOCKED;
        ref_ok <= 1'b1;
      end else if (go_search) begin
        state  <= SEARCH;
        ref_ok <= 1'b0;
      end
    end
  end

  // Divider channels; a state change restarts them and drops that tick.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_ref_monitor_div_ch #(.DIV_W(DIV_W)) u_ch (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .clr   (trans),
      .ratio (div_ratio[i*DIV_W +: DIV_W]),
      .ce    (ce_out[i])
    );
  end
endmodule

// File: tb/tb_clk_ref_monitor_div.sv
// Bench for clk_ref_monitor_div: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clk_ref_monitor_div;
  localparam int N_CH = 2, DIV_W = 8, WIN = 64, RMIN = 14, RMAX = 18, LOCKW = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  ref_in;
  logic [N_CH*DIV_W-1:0] div_ratio;
  logic                  ref_ok;
  logic [N_CH-1:0]       ce_out;
  logic [15:0]           edge_count;

  int checks = 0, errors = 0;
  int rp = 0, rph = 0;

  clk_ref_monitor_div #(.N_CH(N_CH), .DIV_W(DIV_W), .WIN_CYC(WIN), .REF_MIN(RMIN),
                        .REF_MAX(RMAX), .LOCK_WIN(LOCKW)) dut (
    .clk(clk), .reset(reset), .ref_in(ref_in), .div_ratio(div_ratio),
    .ref_ok(ref_ok), .ce_out(ce_out), .edge_count(edge_count));

  always #5 clk = ~clk;

  // Reference generator: period rp clk cycles (0 = stopped), high for rp/2.
  initial begin
    ref_in = 1'b0;
    forever begin
      @(negedge clk);
      if (rp == 0) ref_in = 1'b0;
      else begin
        rph = (rph + 1) % rp;
        ref_in = (rph < rp / 2);
      end
    end
  end

  // ---------------- behavioural model ----------------
  // m = clk edges since reset release; r1..r3 = ref_in seen 1..3 edges ago
  // (the synchroniser delay); window ends on every WIN-th edge.
  int m, acc, exp_ec, streak;
  bit r1, r2, r3, locked;
  int ticks [N_CH];
  bit [N_CH-1:0] exp_ce;

  always @(posedge clk or posedge reset) begin
    bit re, tk, trans, good;
    int eff;
    if (reset) begin
      m = 0; acc = 0; exp_ec = 0; streak = 0; locked = 0;
      r1 = 0; r2 = 0; r3 = 0; exp_ce = '0;
      for (int i = 0; i < N_CH; i++) ticks[i] = 0;
    end else begin
      m++;
      re = r2 & ~r3;
      r3 = r2; r2 = r1; r1 = ref_in;
      tk = locked ? re : 1'b1;
      acc = (acc + int'(re) > 65535) ? 65535 : acc + int'(re);
      trans = 0;
      if (m % WIN == 0) begin
        exp_ec = acc;
        good = (acc >= RMIN) && (acc <= RMAX);
        acc = 0;
        if (good) begin
          streak = (streak < LOCKW) ? streak + 1 : LOCKW;
          if (!locked && streak == LOCKW) begin locked = 1; trans = 1; end
        end else begin
          streak = 0;
          if (locked) begin locked = 0; trans = 1; end
        end
      end
      for (int i = 0; i < N_CH; i++) begin
        eff = int'(div_ratio[i*DIV_W +: DIV_W]);
        if (eff == 0) eff = 1;
        exp_ce[i] = 1'b0;
        if (trans) ticks[i] = 0;
        else if (tk) begin
          if (ticks[i] + 1 >= eff) begin ticks[i] = 0; exp_ce[i] = 1'b1; end
          else ticks[i]++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit eok; bit [N_CH-1:0] ece; bit [15:0] eec;
    eok = reset ? 1'b0 : locked;
    ece = reset ? '0 : exp_ce;
    eec = reset ? 16'd0 : 16'(exp_ec);
    checks++;
    if (ref_ok !== eok || ce_out !== ece || edge_count !== eec) begin
      errors++;
      $display("FAIL model m=%0d: ref_ok=%b ce_out=%b edge_count=%0d, expected %b %b %0d",
               m, ref_ok, ce_out, edge_count, eok, ece, eec);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the negedge just after model edge 'target'.
  task automatic wait_m(input int target);
    int g = 0;
    while (m < target) begin
      @(negedge clk);
      if (++g > 5000) begin
        errors++; $display("FAIL wait_m timeout: m=%0d target=%0d", m, target); return;
      end
    end
  endtask

  task automatic count_ce0(input int ncyc, output int n);
    n = 0;
    repeat (ncyc) begin @(negedge clk); n += int'(ce_out[0]); end
  endtask

  task automatic set_r(input int ch, input int v);
    div_ratio[ch*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  initial begin
    int n, g;
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g;
    div_ratio = '0;
    set_r(0, 4); set_r(1, 5);
    repeat (3) @(negedge clk);
    chk("rst_ref_ok", int'(ref_ok), 0);
    chk("rst_ce_out", int'(ce_out), 0);
    chk("rst_edge_count", int'(edge_count), 0);

    // Lock with a period-4 reference.
    reset = 1'b0; rp = 4;
    wait_m(64);  chk("win1_ref_ok", int'(ref_ok), 0);
    wait_m(127); chk("pre_lock_ref_ok", int'(ref_ok), 0);
    wait_m(128); chk("lock_ref_ok", int'(ref_ok), 1);
                 chk("win2_edge_count", int'(edge_count), 16);
    wait_m(130);
    count_ce0(64, n); chk("ratio4_locked_pulses", n, 4);
    set_r(0, 0);
    count_ce0(64, n); chk("ratio0_locked_pulses", n, 16);
    chk("win3_edge_count", int'(edge_count), 16);

    // Stop the reference: drop lock, then hold over on the local clock.
    set_r(0, 4); rp = 0;
    wait_m(320);
    chk("stop_ref_ok", int'(ref_ok), 0);
    chk("stop_edge_low", int'(edge_count < 16'd14), 1);
    count_ce0(32, n); chk("holdover_pulses", n, 8);

    // Period 2: too many edges, never locks.
    rp = 2;
    wait_m(448);
    chk("fast_edge_count", int'(edge_count), 32);
    chk("fast_ref_ok", int'(ref_ok), 0);

    // Ratio lowered 10 -> 3 while the counter sits at 7.
    set_r(0, 10);
    g = 0;
    while (ticks[0] != 7 && g < 40) begin @(negedge clk); g++; end
    chk("cnt7_reached", ticks[0], 7);
    set_r(0, 3);
    @(negedge clk); chk("ratio_drop_immediate", int'(ce_out[0]), 1);
    @(negedge clk); chk("ratio_drop_gap1", int'(ce_out[0]), 0);
    @(negedge clk); chk("ratio_drop_gap2", int'(ce_out[0]), 0);
    @(negedge clk); chk("ratio_drop_next", int'(ce_out[0]), 1);

    // Randomized periods and ratio changes, mostly lock-friendly.
    for (int w = 0; w < 12; w++) begin
      case ($urandom_range(0, 6))
        0: rp = 0; 1: rp = 2; 2: rp = 3; 3: rp = 5; default: rp = 4;
      endcase
      for (int c = 0; c < WIN; c++) begin
        @(negedge clk);
        if ($urandom_range(0, 15) == 0) set_r($urandom_range(0, N_CH - 1), $urandom_range(0, 12));
      end
    end

    // Asynchronous reset while locked and mid-pulse.
    rp = 4; set_r(0, 0);
    g = 0;
    while (!locked && g < 400) begin @(negedge clk); g++; end
    chk("relock_before_reset", int'(locked), 1);
    g = 0;
    while (ce_out[0] !== 1'b1 && g < 40) begin @(negedge clk); g++; end
    chk("pulse_before_reset", int'(ce_out[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_ref_ok", int'(ref_ok), 0);
    chk("async_rst_ce_out", int'(ce_out), 0);
    chk("async_rst_edge_count", int'(edge_count), 0);
    @(negedge clk); reset = 1'b0;
    wait_m(64);  chk("post_rst_win1_ref_ok", int'(ref_ok), 0);
    wait_m(127); chk("post_rst_pre_lock", int'(ref_ok), 0);
    wait_m(128); chk("post_rst_lock", int'(ref_ok), 1);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
